dmax_frame_capture: RTL
=======================

# dmax_frame_capture

Passive receiver for the 8x16 dot-matrix scan interface driven by the game's display scanner. It watches the active-low one-hot row strobe and the two 8-bit column buses, and rebuilds the 128-bit frame image that is being scanned out. It presents each completed frame to a consumer with a valid/ack handshake. It sits beside the matrix pins as a readback and checking block, and flags scan-protocol violations.

## Interface

Parameters:

- SETTLE, 4: consecutive cycles a row code must be stable in the input register before columns are sampled (legal range 1..255).
- TIMEOUT, 4096: cycles a row may stay unchanged while locked before the stream is declared stalled (must be > SETTLE).

Ports:

- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- dmax_row  in  8  row strobe; bit k low means row k is selected.
- dmax_col0  in  8  low column byte.
- dmax_col1  in  8  high column byte.
- frame  out  128  last completed image; row k occupies frame[16k+15:16k] = {dmax_col1, dmax_col0}.
- frame_valid  out  1  a new frame is held in `frame` and has not been acknowledged.
- frame_ack  in  1  consumer acknowledge; clears frame_valid.
- locked  out  1  capture is synchronised to the sweep.
- err_order  out  1  sticky; row sequence violation.
- err_illegal  out  1  sticky; row code not exactly one zero bit.
- err_timeout  out  1  sticky; row stalled.
- overrun  out  1  sticky; a frame was overwritten before it was acknowledged.

## Operation

Input path:

- All three inputs are registered once into r_row and r_col; nothing else samples the raw pins.
- A change is detected when r_row differs from its previous value.
- stable_cnt clears on a change and otherwise increments, saturating at TIMEOUT.
- Legal row codes: 8'hFE, FD, FB, F7, EF, DF, BF, 7F, meaning row index k = 0..7.
- The required sweep order is 0,1,...,7,0.
- Any other code is illegal, including 8'hFF.

States (state SYNC is the reset state):

- SYNC (locked=0): wait until r_row==8'hFE has been stable SETTLE cycles. Then sample r_col into shadow row 0, set expect=1, and go to HOLD.
  - Illegal codes in SYNC are ignored, with no error.
- HOLD (locked=1), on a change:
  - New code equals row `expect`: go to ARM.
  - New code is legal but not `expect`: set err_order and go to SYNC.
  - New code is illegal: set err_illegal and go to SYNC.
- HOLD, with no change: if stable_cnt reaches TIMEOUT, set err_timeout and go to SYNC.
- ARM (locked=1):
  - When stable_cnt reaches SETTLE-1 on the cycle before sampling (i.e. SETTLE stable cycles), sample r_col into shadow row `expect`.
  - If expect==7, commit the frame, set expect=0, and go to HOLD.
  - Otherwise set expect=expect+1 and go to HOLD.
  - Any change in ARM before the sample is a glitch: set err_order and go to SYNC.
- Going to SYNC discards the partial shadow. `frame` keeps its old contents.

Commit:

- `frame` takes the shadow rows 0..6 plus the row-7 sample, in the same edge.
- frame_valid is set to 1.
- If frame_valid was already 1 and frame_ack is low in that cycle, overrun is set. The frame is still overwritten.

Handshake:

- frame_ack while frame_valid=1 clears frame_valid on the next edge.
- If ack and commit occur in the same cycle, frame_valid stays 1 and overrun is not set.
- Ack while frame_valid=0 is ignored.

## Timing

Reset values:

- frame = 0, frame_valid = 0, locked = 0.
- All error flags = 0, overrun = 0.
- state = SYNC, expect = 0, stable_cnt = 0, shadow = 0.

Latency:

- From a pin change to the column sample: 1 + SETTLE edges.
- From the row-7 sample to frame/frame_valid visibility: 0. Both update on the sampling edge.

Other rules:

- The earliest frame after reset or loss of lock completes on the first row-7 sample following a full 0..7 run.
- The error flags and overrun clear only on reset.
- Reset asserted mid-sweep returns everything to the reset values on the next edge. Capture restarts from SYNC.

## Test plan

- Writer model holds each row 1001 cycles, sweeping 0..7 with image 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → after the first row 7 is held 1+SETTLE cycles, frame equals the image, frame_valid=1, and no error flags are set.
- Start the sweep at row 3 → locked=0 until row 0 is stable 4 cycles. The first frame_valid comes at the end of the next row 7. No errors are raised.
- While locked, jump from row 1 to row 3 → err_order=1, locked=0, frame unchanged. The next full sweep recaptures correctly.
- While locked, drive 8'hFF, then separately 8'hFC → err_illegal=1 and loss of lock. Driving 8'hFC while in SYNC sets no flag.
- Hold row 4 for 5000 cycles → err_timeout=1 and locked=0 at stable_cnt=4096.
- Two frames complete with no ack → overrun=1 and frame holds the second image.
  - Repeat with frame_ack pulsed on the commit cycle → frame_valid=1 and overrun=0.
- Assert reset during row 5 → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/dmax_frame_capture_if.sv
// dmax_frame_capture_if: scan pins, frame output and status/handshake bundle; master = scanner/consumer side, slave = capture block
interface dmax_frame_capture_if;
  logic [7:0]   dmax_row;
  logic [7:0]   dmax_col0;
  logic [7:0]   dmax_col1;
  logic [127:0] frame;
  logic         frame_valid;
  logic         frame_ack;
  logic         locked;
  logic         err_order;
  logic         err_illegal;
  logic         err_timeout;
  logic         overrun;
  modport master (
    output dmax_row, dmax_col0, dmax_col1, frame_ack,
    input  frame, frame_valid, locked, err_order, err_illegal, err_timeout, overrun
  );
  modport slave (
    input  dmax_row, dmax_col0, dmax_col1, frame_ack,
    output frame, frame_valid, locked, err_order, err_illegal, err_timeout, overrun
  );
endinterface

// File: rtl/dmax_frame_capture.sv
// dmax_frame_capture: rebuilds the 8x16 dot-matrix image from the row/column scan (in: clock, reset, bus row/cols/ack; out: bus frame, frame_valid, locked, err_order/illegal/timeout, overrun)
module dmax_frame_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input logic                 clock,
  input logic                 reset,
  dmax_frame_capture_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] ARM  = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [7:0]    row_q, prev_q, low;
  logic [15:0]   col_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    expect_q, expect_d;
  logic [127:0]  shadow_q, shadow_d, frame_q, frame_d;
  logic          valid_q, valid_d, eo_q, eo_d, ei_q, ei_d, et_q, et_d, ov_q, ov_d;
  logic          chg, legal, settled, is_exp, commit;
  assign chg     = row_q != prev_q;
  assign low     = ~row_q;
  assign legal   = low != 8'd0 && (low & (low - 8'd1)) == 8'd0;
  assign settled = !chg && cnt_q >= CW'(SETTLE - 1);
  assign is_exp  = row_q == ~(8'd1 << expect_q);
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    shadow_d = shadow_q;
    eo_d     = eo_q;
    ei_d     = ei_q;
    et_d     = et_q;
    commit   = 1'b0;
    case (state_q)
      SYNC: if (settled && row_q == 8'hFE) begin
        shadow_d[15:0] = col_q;
        expect_d       = 3'd1;
        state_d        = HOLD;
      end
      HOLD: if (chg) begin
        state_d = is_exp ? ARM : SYNC;
        eo_d    = eo_q | (legal & !is_exp);
        ei_d    = ei_q | !legal;
      end else if (cnt_q == CW'(TIMEOUT)) begin
        et_d    = 1'b1;
        state_d = SYNC;
      end
      ARM: if (chg) begin
        eo_d    = 1'b1;
        state_d = SYNC;
      end else if (settled) begin
        shadow_d[{expect_q, 4'd0} +: 16] = col_q;
        commit   = expect_q == 3'd7;
        expect_d = expect_q + 3'd1;
        state_d  = HOLD;
      end
      default: state_d = SYNC;
    endcase
  end
  assign cnt_d   = chg ? '0 : cnt_q + CW'(cnt_q != CW'(TIMEOUT));
  assign frame_d = commit ? shadow_d : frame_q;
  assign valid_d = commit | (valid_q & ~bus.frame_ack);
  assign ov_d    = ov_q | (commit & valid_q & ~bus.frame_ack);
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q    <= 8'hFF;
      prev_q   <= 8'hFF;
      col_q    <= '0;
      cnt_q    <= '0;
      state_q  <= SYNC;
      expect_q <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      eo_q     <= 1'b0;
      ei_q     <= 1'b0;
      et_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      row_q    <= bus.dmax_row;
      prev_q   <= row_q;
      col_q    <= {bus.dmax_col1, bus.dmax_col0};
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      expect_q <= expect_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      eo_q     <= eo_d;
      ei_q     <= ei_d;
      et_q     <= et_d;
      ov_q     <= ov_d;
    end
  end
  assign bus.frame       = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.locked      = state_q != SYNC;
  assign bus.err_order   = eo_q;
  assign bus.err_illegal = ei_q;
  assign bus.err_timeout = et_q;
  assign bus.overrun     = ov_q;
endmodule
